// File: rtl/axi_wr_burst_pkg.sv
// Shared AXI4 write-burst definitions: channel field widths, fixed encodings and FSM states.
// Imported by the burst engine and usable by any sibling block on the same bus.
package axi_wr_burst_pkg;

    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [1:0]             AXI_RESP_OKAY     = 2'b00;
    localparam logic [3:0]             AXI_CACHE_DEFAULT = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_e;

    // AxSIZE encoding for a bus that is 'bytes' wide.
    function automatic logic [AXI_SIZE_W-1:0] axiSize(input int bytes);
        return AXI_SIZE_W'($clog2(bytes));
    endfunction

endpackage

// File: rtl/axi_wr_burst.sv
// AXI4 write-burst engine: one INCR burst per accepted run.
// Write data is streamed straight from the FIFO read port onto the W channel.
module axi_wr_burst
    import axi_wr_burst_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_ID_W  = 1,
    parameter int AXI_LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   run,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [AXI_LEN_W-1:0]   length,
    output logic                   ready,
    output logic                   error,

    input  logic                   s_valid,
    input  logic [DATA_W-1:0]      s_wdata,
    input  logic [DATA_W/8-1:0]    s_wstrb,
    output logic                   s_ready,

    output logic [AXI_ID_W-1:0]    m_axi_awid,
    output logic [ADDR_W-1:0]      m_axi_awaddr,
    output logic [AXI_LEN_W-1:0]   m_axi_awlen,
    output logic [AXI_SIZE_W-1:0]  m_axi_awsize,
    output logic [AXI_BURST_W-1:0] m_axi_awburst,
    output logic                   m_axi_awlock,
    output logic [3:0]             m_axi_awcache,
    output logic [2:0]             m_axi_awprot,
    output logic [3:0]             m_axi_awqos,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,

    output logic [DATA_W-1:0]      m_axi_wdata,
    output logic [DATA_W/8-1:0]    m_axi_wstrb,
    output logic                   m_axi_wlast,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,

    input  logic [AXI_ID_W-1:0]    m_axi_bid,
    input  logic [1:0]             m_axi_bresp,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready
);

    localparam int BYTES = DATA_W / 8;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [AXI_LEN_W-1:0]   len_q, len_d;
    logic [AXI_LEN_W-1:0]   cnt_q, cnt_d;
    logic                   error_q, error_d;
    logic                   beatLast;
    logic                   unused_bid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    // The counter only ever reaches len_q before returning to 0, so a full-width length cannot wrap early.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        error_d       = error_q;
        beatLast      = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        s_ready       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    addr_d  = addr;
                    len_d   = length;
                    error_d = 1'b0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                beatLast     = (cnt_q == len_q);
                m_axi_wvalid = s_valid;
                m_axi_wlast  = beatLast;
                s_ready      = m_axi_wready;
                if (s_valid && m_axi_wready) begin
                    if (beatLast) begin
                        cnt_d   = '0;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d = cnt_q + AXI_LEN_W'(1);
                    end
                end
            end
            ST_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    error_d = (m_axi_bresp != AXI_RESP_OKAY);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ready         = (state_q == ST_IDLE);
    assign error         = error_q;

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = axiSize(BYTES);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = AXI_CACHE_DEFAULT;
    assign m_axi_awprot  = '0;
    assign m_axi_awqos   = '0;

    assign m_axi_wdata   = s_wdata;
    assign m_axi_wstrb   = s_wstrb;

    assign unused_bid    = ^m_axi_bid;

    // Bursts are issued as given; the caller is expected to keep them inside one 4 KB page.
    assert property (@(posedge clk) disable iff (!rst)
        (ready && run) |-> (int'(addr[11:0]) + (int'(length) + 1) * BYTES <= 4096));

endmodule

// File: doc/axi_wr_burst.md
Name:
axi_wr_burst

Overview:
- AXI4 write-burst engine that sits directly downstream of the iob2axi write FIFO.
- The caller fires `run` with a start address and a burst length. The block then issues exactly one AXI4 INCR write burst.
- Write data is pulled from a native valid/ready stream, i.e. the FIFO read side.
- Ready and error are reported back to the control logic that sequences bursts.

Parameters:
- ADDR_W, 32: AXI address width.
- DATA_W, 32: data width; multiple of 8, power of 2.
- AXI_ID_W, 1: AXI ID width.
- AXI_LEN_W, 8: AXI burst-length field width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: asynchronous, active-low (asserted when 0).
- run  input  1  start a burst; sampled only while ready=1.
- addr  input  ADDR_W  burst start address.
- length  input  AXI_LEN_W  beats minus 1; copied to awlen.
- ready  output  1  engine idle, can accept run.
- error  output  1  last burst got a non-OKAY bresp.
- s_valid  input  1  write data available.
- s_wdata  input  DATA_W  write data.
- s_wstrb  input  DATA_W/8  byte strobes.
- s_ready  output  1  beat consumed this cycle.
- m_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos/awvalid  output  AXI4 write-address channel; widths AXI_ID_W/ADDR_W/AXI_LEN_W/3/2/1/4/3/4/1.
- m_axi_awready  input  1  write-address channel ready.
- m_axi_wdata/wstrb/wlast/wvalid  output  write-data channel; widths DATA_W/DATA_W/8/1/1.
- m_axi_wready  input  1  write-data channel ready.
- m_axi_bid  input  AXI_ID_W  response ID.
- m_axi_bresp  input  2  response code.
- m_axi_bvalid  input  1  response valid.
- m_axi_bready  output  1  response ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE; ready=1; error=0.
  - awvalid=0, wvalid=0, bready=0, s_ready=0.
  - Beat counter=0; latched addr/len=0.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - On run=1, latch addr and length and clear error; next cycle goes to ADDR with ready=0.
  - run while not IDLE is ignored.
- ADDR:
  - awvalid=1 (registered); awaddr/awlen come from the latches.
  - Constant fields:
    - awsize=log2(DATA_W/8); awburst=2'b01 (INCR).
    - awid=0, awlock=0, awcache=4'b0011, awprot=0, awqos=0.
  - On awvalid&awready, the next cycle is DATA and awvalid=0.
  - AW values hold stable while awvalid=1 and awready=0.
- DATA:
  - Combinational pass-through, no extra latency:
    - wvalid=s_valid, wdata=s_wdata, wstrb=s_wstrb.
    - s_ready=wready.
  - Beat handshake = s_valid&wready; the counter increments on each handshake.
  - wlast=1 when counter==latched length.
  - Handshake with wlast: next state RESP; counter reset to 0.
  - s_ready=0 outside DATA, so no beats are consumed early. W never precedes AW.
- RESP:
  - bready=1.
  - On bvalid: error<=(bresp!=2'b00) (SLVERR/DECERR), sticky until the next accepted run; next state IDLE with ready=1.
  - bid is ignored.
- Throughput: minimum burst duration = 1 (IDLE→ADDR) + 1 (AW) + (length+1) beats + 1 (B) cycles.
- Boundaries:
  - length=0: single beat with wlast=1.
  - length=2^AXI_LEN_W-1: counter must not wrap before wlast.
  - s_valid gaps: wvalid drops and the counter holds.
  - Simultaneous awready and the first data beat are impossible by construction (states are sequential).
- Address rules: 4 KB boundary compliance is the caller's responsibility; the burst is issued as given. A simulation-only assertion flags (addr mod 4096)+(length+1)*DATA_W/8 > 4096.
- Reset mid-burst: outputs drop asynchronously; the burst is abandoned; no recovery of the partial transfer.

Decomposition:
- Shared package/header (axi.vh):
  - AXI_LEN_W, AXI_SIZE_W=3, AXI_BURST_W=2.
  - AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00.
  - FSM state encodings; the AXI4 write port macro.
- No sub-module: FSM plus beat counter plus latches in one module.

Test Plan:
- run, addr=0x1000, length=0; awready=1, wready=1, bresp=OKAY:
  - awaddr=0x1000, awlen=0.
  - One W beat with wlast=1.
  - ready returns 1 after B; error=0.
- length=3, data 0xA0..0xA3:
  - Check AW holds stable across 3 cycles of awready=0.
  - Toggle wready 1,0,1,0.
  - Exactly 4 beats in order; wlast only on 0xA3; s_ready mirrors wready.
- length=7 with s_valid gaps after beats 2 and 5: wvalid=0 during gaps; the counter holds; wlast falls on the 8th beat.
- bresp=2'b10 (SLVERR): error=1 after the burst and stays 1 until the next run; then OKAY clears it.
- run pulsed during DATA: ignored; only one AW handshake per accepted run.
- rst=0 asserted during beat 3 of length=15: awvalid/wvalid/bready drop immediately; ready=1; the next burst completes normally.
